cache_line_writeback: RTL and testbench

- Evicts one dirty cache line to main memory.
- On request, reads the line for {index, channel} from the cache data memory (combinational read port) and sends the line address on a valid/ready address channel.
- Then streams the line on a narrower valid/ready write-data bus, lowest beat first, and waits for a write acknowledge.
- Sits between the cache controller and the memory bus interface; it is the reading end of the data memory.

---
 rtl/cache_pkg.sv | 27 ++
 rtl/wb_line_serializer.sv | 44 ++++
 rtl/cache_line_writeback.sv | 128 ++++++++++++
 tb/tb_cache_line_writeback.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, beat count, writeback FSM encoding and line address helper
package cache_pkg;

    localparam int AINDEX_WIDTH   = 8;
    localparam int CH_NUM_WIDTH   = 2;
    localparam int CASH_STR_WIDTH = 64;
    localparam int TAG_WIDTH      = 8;
    localparam int BUS_WIDTH      = 16;
    localparam int BEATS          = CASH_STR_WIDTH / BUS_WIDTH;
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        WB_IDLE,
        WB_READ,
        WB_ADDR,
        WB_DATA,
        WB_WAIT_ACK
    } wb_state_t;

    function automatic logic [TAG_WIDTH+AINDEX_WIDTH-1:0] line_addr(
        input logic [TAG_WIDTH-1:0]    tag,
        input logic [AINDEX_WIDTH-1:0] index
    );
        return {tag, index};
    endfunction

endpackage

// File: rtl/wb_line_serializer.sv
// rtl/wb_line_serializer.sv - loads one cache line and emits it as BUS_WIDTH beats, lowest beat first
module wb_line_serializer
    import cache_pkg::*;
#(
    parameter int LINE_W = CASH_STR_WIDTH,
    parameter int BUS_W  = BUS_WIDTH
) (
    input  logic              clk,
    input  logic              not_reset,
    input  logic              load,
    input  logic [LINE_W-1:0] line_data,
    input  logic              send,
    output logic [BUS_W-1:0]  tdata,
    output logic              tvalid,
    input  logic              tready,
    output logic              tlast,
    output logic              last_accepted
);

    localparam int N_BEATS = LINE_W / BUS_W;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    logic [LINE_W-1:0] shift_reg;
    logic [CNT_W-1:0]  beat_cnt;

    assign tvalid        = send;
    assign tdata         = shift_reg[BUS_W-1:0];
    assign tlast         = send && (beat_cnt == CNT_W'(N_BEATS - 1));
    assign last_accepted = tvalid && tready && tlast;

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            shift_reg <= '0;
            beat_cnt  <= '0;
        end else if (load) begin
            shift_reg <= line_data;
            beat_cnt  <= '0;
        end else if (tvalid && tready) begin
            shift_reg <= shift_reg >> BUS_W;
            beat_cnt  <= tlast ? '0 : beat_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cache_line_writeback.sv
// rtl/cache_line_writeback.sv - evicts one dirty line: read data memory, send address, stream beats, await ack
// Optional ack timeout enabled by defining WB_ACK_TIMEOUT_EN.
module cache_line_writeback
    import cache_pkg::*;
(
    input  logic                              clk,
    input  logic                              not_reset,
    input  logic                              wb_req,
    input  logic [AINDEX_WIDTH-1:0]           wb_index,
    input  logic [CH_NUM_WIDTH-1:0]           wb_channel,
    input  logic [TAG_WIDTH-1:0]              wb_tag,
    output logic                              wb_busy,
    output logic                              wb_done,
    output logic                              wb_error,
    output logic [AINDEX_WIDTH-1:0]           dm_index,
    output logic [CH_NUM_WIDTH-1:0]           dm_channel,
    input  logic [CASH_STR_WIDTH-1:0]         dm_data,
    output logic [TAG_WIDTH+AINDEX_WIDTH-1:0] mem_addr,
    output logic                              mem_addr_valid,
    input  logic                              mem_addr_ready,
    output logic [BUS_WIDTH-1:0]              mem_wdata,
    output logic                              mem_wdata_valid,
    output logic                              mem_wdata_last,
    input  logic                              mem_wdata_ready,
    input  logic                              mem_ack
);

    wb_state_t state, next_state;

    logic [AINDEX_WIDTH-1:0] index_q;
    logic [CH_NUM_WIDTH-1:0] channel_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    last_accepted;
    logic                    ack_timeout;

`ifdef WB_ACK_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] to_cnt;
    logic            error_q;

    // Counts WAIT_ACK cycles without an ack; expires at the end of the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            to_cnt <= '0;
        end else if (state == WB_WAIT_ACK && !mem_ack) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign ack_timeout = (state == WB_WAIT_ACK) && !mem_ack
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= ack_timeout;
        end
    end

    assign wb_error = error_q;
`else
    assign ack_timeout = 1'b0;
    assign wb_error    = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            WB_IDLE:     if (wb_req) next_state = WB_READ;
            WB_READ:     next_state = WB_ADDR;
            WB_ADDR:     if (mem_addr_ready) next_state = WB_DATA;
            WB_DATA:     if (last_accepted) next_state = WB_WAIT_ACK;
            WB_WAIT_ACK: if (mem_ack || ack_timeout) next_state = WB_IDLE;
            default:     next_state = WB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge not_reset) begin
        if (!not_reset) begin
            state     <= WB_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            index_q   <= '0;
            channel_q <= '0;
            tag_q     <= '0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != WB_IDLE);
            done_q <= (state == WB_WAIT_ACK) && (mem_ack || ack_timeout);
            if (state == WB_IDLE && wb_req) begin
                index_q   <= wb_index;
                channel_q <= wb_channel;
                tag_q     <= wb_tag;
            end
        end
    end

    assign wb_busy        = busy_q;
    assign wb_done        = done_q;
    assign dm_index       = index_q;
    assign dm_channel     = channel_q;
    assign mem_addr       = line_addr(tag_q, index_q);
    assign mem_addr_valid = (state == WB_ADDR);

    // The shift register captures dm_data on the edge that ends READ.
    wb_line_serializer #(
        .LINE_W (CASH_STR_WIDTH),
        .BUS_W  (BUS_WIDTH)
    ) u_serializer (
        .clk           (clk),
        .not_reset     (not_reset),
        .load          (state == WB_READ),
        .line_data     (dm_data),
        .send          (state == WB_DATA),
        .tdata         (mem_wdata),
        .tvalid        (mem_wdata_valid),
        .tready        (mem_wdata_ready),
        .tlast         (mem_wdata_last),
        .last_accepted (last_accepted)
    );

endmodule

// File: tb/tb_cache_line_writeback.sv
// tb/tb_cache_line_writeback.sv - scoreboard bench: stimulus queues expectations, negedge monitor checks them
module tb_cache_line_writeback;
    import cache_pkg::*;

    logic                              clk = 1'b0;
    logic                              not_reset = 1'b0;
    logic                              wb_req = 1'b0;
    logic [AINDEX_WIDTH-1:0]           wb_index = '0;
    logic [CH_NUM_WIDTH-1:0]           wb_channel = '0;
    logic [TAG_WIDTH-1:0]              wb_tag = '0;
    logic                              wb_busy, wb_done, wb_error;
    logic [AINDEX_WIDTH-1:0]           dm_index;
    logic [CH_NUM_WIDTH-1:0]           dm_channel;
    logic [CASH_STR_WIDTH-1:0]         dm_data;
    logic [TAG_WIDTH+AINDEX_WIDTH-1:0] mem_addr;
    logic                              mem_addr_valid;
    logic                              mem_addr_ready = 1'b1;
    logic [BUS_WIDTH-1:0]              mem_wdata;
    logic                              mem_wdata_valid, mem_wdata_last;
    logic                              mem_wdata_ready = 1'b1;
    logic                              mem_ack = 1'b1;

    cache_line_writeback dut (
        .clk             (clk),
        .not_reset       (not_reset),
        .wb_req          (wb_req),
        .wb_index        (wb_index),
        .wb_channel      (wb_channel),
        .wb_tag          (wb_tag),
        .wb_busy         (wb_busy),
        .wb_done         (wb_done),
        .wb_error        (wb_error),
        .dm_index        (dm_index),
        .dm_channel      (dm_channel),
        .dm_data         (dm_data),
        .mem_addr        (mem_addr),
        .mem_addr_valid  (mem_addr_valid),
        .mem_addr_ready  (mem_addr_ready),
        .mem_wdata       (mem_wdata),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_last  (mem_wdata_last),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_ack         (mem_ack)
    );

    always #5 clk = ~clk;

    logic [CASH_STR_WIDTH-1:0] line_mem [0:1023];
    assign dm_data = line_mem[{dm_index, dm_channel}];

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s actual=%0h required=none", name, act);
    endtask

    typedef struct {
        bit err;
        int lat;
    } done_t;

    logic [15:0] addr_q [$];
    logic [16:0] beat_q [$];
    done_t       done_q [$];
    int          req_cyc = 0;
    int          beats_seen = 0;

    // ---------------- monitor ----------------
    logic        prev_av = 0, prev_ar = 0, prev_wv = 0, prev_wr = 0, prev_last = 0;
    logic [15:0] prev_addr = 0, prev_wd = 0;
    done_t       d;

    always @(negedge clk) begin
        if (!not_reset) begin
            prev_av = 0;
            prev_wv = 0;
        end else begin
            if (prev_av && !prev_ar) begin
                check("addr_hold_valid", mem_addr_valid, 1'b1);
                check("addr_hold_value", mem_addr, prev_addr);
            end
            if (prev_wv && !prev_wr) begin
                check("wdata_hold_valid", mem_wdata_valid, 1'b1);
                check("wdata_hold_value", {mem_wdata_last, mem_wdata}, {prev_last, prev_wd});
            end
            if (mem_wdata_valid)
                check("no_addr_during_data", mem_addr_valid, 1'b0);
            if (mem_addr_valid && mem_addr_ready) begin
                if (addr_q.size() == 0) unexpected("addr_unexpected", mem_addr);
                else check("mem_addr", mem_addr, addr_q.pop_front());
            end
            if (mem_wdata_valid && mem_wdata_ready) begin
                beats_seen++;
                if (beat_q.size() == 0) unexpected("beat_unexpected", {mem_wdata_last, mem_wdata});
                else check("beat_last_data", {mem_wdata_last, mem_wdata}, beat_q.pop_front());
            end
            if (wb_done) begin
                if (done_q.size() == 0) unexpected("done_unexpected", wb_done);
                else begin
                    d = done_q.pop_front();
                    check("wb_error", wb_error, d.err);
                    if (d.lat > 0) check("done_latency", cyc - req_cyc + 1, d.lat);
                end
            end else if (wb_error) begin
                check("error_without_done", wb_error, 1'b0);
            end
            prev_av   = mem_addr_valid;
            prev_ar   = mem_addr_ready;
            prev_addr = mem_addr;
            prev_wv   = mem_wdata_valid;
            prev_wr   = mem_wdata_ready;
            prev_wd   = mem_wdata;
            prev_last = mem_wdata_last;
        end
    end

    // ---------------- write-data ready pattern driver ----------------
    bit rdy_mode = 0;
    bit pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int pk = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode) begin
            mem_wdata_ready = pat[pk % 4];
            pk++;
        end else begin
            mem_wdata_ready = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] idx, input logic [1:0] ch, input logic [7:0] tag,
                         input logic [63:0] line, input int lat, input bit expect_done);
        done_t e;
        line_mem[{idx, ch}] = line;
        addr_q.push_back({tag, idx});
        for (int i = 0; i < 4; i++) beat_q.push_back({(i == 3), line[i*16 +: 16]});
        if (expect_done) begin
            e.err = 0;
            e.lat = lat;
            done_q.push_back(e);
        end
        @(posedge clk); #1;
        wb_req = 1'b1; wb_index = idx; wb_channel = ch; wb_tag = tag;
        @(posedge clk); #1;
        req_cyc = cyc;
        wb_req = 1'b0;
        check("busy_after_req", wb_busy, 1'b1);
        check("dm_index", dm_index, idx);
        check("dm_channel", dm_channel, ch);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (wb_busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, wb_busy, 1'b0);
    endtask

    localparam logic [63:0] LINE1 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] LINE2 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] LINE3 = 64'h0F0F_F0F0_AAAA_5555;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, n;
        for (int i = 0; i < 1024; i++) line_mem[i] = '0;

        // reset state
        #12;
        check("rst_busy", wb_busy, 1'b0);
        check("rst_done", wb_done, 1'b0);
        check("rst_error", wb_error, 1'b0);
        check("rst_addr_valid", mem_addr_valid, 1'b0);
        check("rst_wdata_valid", mem_wdata_valid, 1'b0);
        check("rst_wdata_last", mem_wdata_last, 1'b0);
        check("rst_outputs", {mem_addr, mem_wdata, dm_index, dm_channel}, '0);
        @(posedge clk); #1;
        not_reset = 1'b1;

        // full-speed transfer with latency check
        issue(8'h3C, 2'd2, 8'hA5, LINE1, 8, 1);
        wait_idle("t1_idle");

        // write-data ready toggling 1,0,0,1
        rdy_mode = 1;
        pk = 0;
        issue(8'hC3, 2'd1, 8'h5A, LINE2, 0, 1);
        wait_idle("t2_idle");
        rdy_mode = 0;
        check("t2_beats_left", beat_q.size(), 0);

        // address ready stalled for 5 cycles
        mem_addr_ready = 1'b0;
        issue(8'h3C, 2'd2, 8'hA5, LINE1, 0, 1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            check("stall_addr_valid", mem_addr_valid, 1'b1);
            check("stall_addr", mem_addr, 16'hA53C);
            check("stall_no_data", mem_wdata_valid, 1'b0);
            @(posedge clk); #1;
        end
        mem_addr_ready = 1'b1;
        wait_idle("t3_idle");

        // request during DATA is ignored
        issue(8'h3C, 2'd2, 8'hA5, LINE1, 0, 1);
        n = 0;
        while (!mem_wdata_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t4_reach_data", mem_wdata_valid, 1'b1);
        wb_req = 1'b1; wb_index = 8'h11; wb_channel = 2'd0; wb_tag = 8'h77;
        @(posedge clk); #1;
        wb_req = 1'b0;
        check("t4_dm_index_held", dm_index, 8'h3C);
        check("t4_dm_channel_held", dm_channel, 2'd2);
        wait_idle("t4_idle");
        repeat (4) @(posedge clk);
        #1;
        check("t4_busy_stays_low", wb_busy, 1'b0);
        check("t4_done_left", done_q.size(), 0);

        // reset after beat 2
        issue(8'h3C, 2'd2, 8'hA5, LINE1, 0, 1);
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("t5_two_beats", beats_seen - base, 2);
        #2;
        not_reset = 1'b0;
        addr_q.delete();
        beat_q.delete();
        done_q.delete();
        #1;
        check("t5_wdata_valid_drop", mem_wdata_valid, 1'b0);
        check("t5_addr_valid_drop", mem_addr_valid, 1'b0);
        check("t5_busy_drop", wb_busy, 1'b0);
        check("t5_last_drop", mem_wdata_last, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        not_reset = 1'b1;
        repeat (3) @(posedge clk);
        issue(8'h01, 2'd3, 8'hFF, LINE3, 8, 1);
        wait_idle("t5_idle");

        // ack never arrives: default build waits indefinitely
        mem_ack = 1'b0;
        issue(8'hC3, 2'd1, 8'h5A, LINE2, 0, 0);
        repeat (300) @(posedge clk);
        #1;
        check("t6_busy_held", wb_busy, 1'b1);
        check("t6_no_data_valid", mem_wdata_valid, 1'b0);
        check("t6_beats_left", beat_q.size(), 0);
        not_reset = 1'b0;
        #3;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        not_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("end_addr_q", addr_q.size(), 0);
        check("end_beat_q", beat_q.size(), 0);
        check("end_done_q", done_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
